memory: RTL and testbench

- Single-port synchronous RAM with a valid/ready request interface.
- Each request is a write or a read of one WIDTH-bit word at addr_i.
- Used as a generic on-chip storage block; one request is accepted per clock when ready.

---
 rtl/memory.sv | 42 ++++
 tb/tb_memory.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Single-port synchronous RAM behind a valid/ready request interface.
// One word is written or read per accepted request; read data is registered.
module memory #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             r_ready;
  logic             w_acc;

  assign w_acc   = valid_i & r_ready;
  assign rdata_o = r_rdata;
  assign ready_o = r_ready;

  // Storage is flop-based so every location clears asynchronously with rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_acc) begin
        if (wr_rd_i) r_mem[addr_i] <= wdata_i;
        else         r_rdata       <= r_mem[addr_i];
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// Randomized scoreboard bench for memory: driver pushes expected read data,
// a monitor pops and compares whenever a read completes.
module tb_memory;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_rd = 1'b0;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [AW-1:0]    addr = '0;
  logic [WIDTH-1:0] rdata;
  logic             ready;

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .wr_rd_i(wr_rd), .valid_i(valid),
    .wdata_i(wdata), .addr_i(addr), .rdata_o(rdata), .ready_o(ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array of words plus a queue of expected read results.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: acceptance is judged from pre-edge values, data checked 1 unit later.
  logic [WIDTH-1:0] last_rd = '0;
  always @(posedge clk) begin : mon
    logic acc;
    logic [WIDTH-1:0] e;
    acc = !rst && valid && ready && !wr_rd;
    #1;
    if (rst) last_rd = '0;
    else if (acc) begin
      if (exp_q.size() == 0) chk("unexpected_read", rdata, 'x);
      else begin
        e = exp_q.pop_front();
        chk("read_data", rdata, e);
        last_rd = e;
      end
    end else chk("rdata_hold", rdata, last_rd);
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    clear_model();
    #1;
    chk("rst_rdata", rdata, '0);
    chk("rst_ready", {15'd0, ready}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_rise", {15'd0, ready}, 16'd1);
  endtask

  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    chk("ready_high", {15'd0, ready}, 16'd1);
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d;
    if (wr) ref_mem[a] = d;
    else    exp_q.push_back(ref_mem[a]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      wr_rd = 1'($urandom); addr = AW'($urandom); wdata = WIDTH'($urandom);
    end
  endtask

  task automatic range_test(input int lo, input int hi);
    do_reset();
    for (int a = lo; a <= hi; a++) req(1'b1, AW'(a), WIDTH'($urandom));
    for (int a = 0; a < DEPTH; a++) req(1'b0, AW'(a), '0);
    idle(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: timeout reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    clear_model();
    do_reset();

    // Single write, then read it back.
    req(1'b1, 6'd0, 16'h1234);
    idle(2);
    req(1'b0, 6'd0, '0);
    idle(2);

    // Full sweep.
    for (int i = 0; i < DEPTH; i++) req(1'b1, AW'(i), WIDTH'(i * 3 + 1));
    for (int i = 0; i < DEPTH; i++) req(1'b0, AW'(i), '0);
    idle(2);

    range_test(15, 20);
    range_test(0, 31);
    range_test(32, 63);
    range_test(0, 15);
    range_test(16, 31);
    range_test(32, 47);
    range_test(48, 63);

    // Alternating write/read with idle gaps.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req(1'b1, AW'(k), WIDTH'($urandom));
      req(1'b0, AW'(k), '0);
      if (k % 3 == 0) idle(2);
    end
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else req(1'($urandom), AW'($urandom), WIDTH'($urandom));
    end
    idle(2);

    // Reset mid-stream, asserted between clock edges.
    req(1'b1, 6'd5, 16'hBEEF);
    req(1'b0, 6'd5, '0);
    @(posedge clk); #3;
    rst = 1'b1; valid = 1'b0;
    clear_model();
    #1;
    chk("midrst_rdata", rdata, '0);
    chk("midrst_ready", {15'd0, ready}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_rise", {15'd0, ready}, 16'd1);
    req(1'b0, 6'd5, '0);
    idle(3);

    chk("queue_drained", 16'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
